// File: rtl/time_keeper.sv
// Time-of-day counter (24 h) with a per-second prescaler and a level load handshake.
// Outputs are registered one cycle after the deciding edge; there is no backpressure path.
module time_keeper #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_en,
    input  logic       load_req,
    input  logic [4:0] load_hour,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    output logic       load_ack,
    output logic       load_err,
    output logic [4:0] cur_hour,
    output logic [5:0] cur_min,
    output logic [5:0] cur_sec,
    output logic       sec_pulse,
    output logic       day_wrap,
    output logic       running
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

    typedef enum logic {
        READY,
        WAIT_REL
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;

    logic load_ok;
    logic accept;
    logic reject;
    logic tick;
    logic at_max;

    assign load_ok = (load_hour <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
    assign accept  = (state == READY) && load_req && load_ok;
    assign reject  = (state == READY) && load_req && !load_ok;
    assign tick    = run_en && (presc == TERM);
    assign at_max  = (cur_hour == 5'd23) && (cur_min == 6'd59) && (cur_sec == 6'd59);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= READY;
            presc     <= '0;
            cur_hour  <= '0;
            cur_min   <= '0;
            cur_sec   <= '0;
            load_ack  <= 1'b0;
            load_err  <= 1'b0;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            running   <= 1'b0;
        end else begin
            running  <= run_en;
            load_ack <= accept;
            load_err <= reject;
            // An accepted load on the terminal-count edge swallows that tick.
            sec_pulse <= tick && !accept;
            day_wrap  <= tick && !accept && at_max;

            case (state)
                READY:    if (load_req)  state <= WAIT_REL;
                WAIT_REL: if (!load_req) state <= READY;
                default:  state <= READY;
            endcase

            if (accept) begin
                cur_hour <= load_hour;
                cur_min  <= load_min;
                cur_sec  <= load_sec;
                presc    <= '0;
            end else if (run_en) begin
                if (tick) begin
                    presc <= '0;
                    if (cur_sec == 6'd59) begin
                        cur_sec <= '0;
                        if (cur_min == 6'd59) begin
                            cur_min  <= '0;
                            cur_hour <= (cur_hour == 5'd23) ? 5'd0 : cur_hour + 5'd1;
                        end else begin
                            cur_min <= cur_min + 6'd1;
                        end
                    end else begin
                        cur_sec <= cur_sec + 6'd1;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper at four ticks per second: a per-cycle vector table
// followed by hand sequences for asynchronous reset in mid-second and mid-handshake.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       run_en = 1'b0;
    logic       load_req = 1'b0;
    logic [4:0] load_hour = '0;
    logic [5:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic       load_ack, load_err, sec_pulse, day_wrap, running;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;

    int n_vec = 0;
    int n_bad = 0;

    time_keeper #(.TICKS_PER_SEC(4)) dut (
        .clk(clk), .reset_n(reset_n), .run_en(run_en), .load_req(load_req),
        .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
        .load_ack(load_ack), .load_err(load_err),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .sec_pulse(sec_pulse), .day_wrap(day_wrap), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        req;
        logic [4:0]  lh;
        logic [5:0]  lm;
        logic [5:0]  ls;
        logic [21:0] exp;
    } vec_t;

    vec_t tv[$];

    wire [21:0] act = {load_ack, load_err, cur_hour, cur_min, cur_sec, sec_pulse, day_wrap, running};

    function automatic logic [21:0] mk_exp(input logic ack, input logic err, input logic [4:0] h,
                                           input logic [5:0] m, input logic [5:0] s,
                                           input logic pulse, input logic wrap, input logic run);
        return {ack, err, h, m, s, pulse, wrap, run};
    endfunction

    task automatic add(input logic run, input logic req, input logic [4:0] lh, input logic [5:0] lm,
                       input logic [5:0] ls, input logic ack, input logic err, input logic [4:0] h,
                       input logic [5:0] m, input logic [5:0] s, input logic pulse, input logic wrap);
        vec_t v;
        v.run = run; v.req = req; v.lh = lh; v.lm = lm; v.ls = ls;
        v.exp = mk_exp(ack, err, h, m, s, pulse, wrap, run);
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [21:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got ack,err,h,m,s,pulse,wrap,run = %0b,%0b,%0d,%0d,%0d,%0b,%0b,%0b expected %0b,%0b,%0d,%0d,%0d,%0b,%0b,%0b",
                     name, act[21], act[20], act[19:15], act[14:9], act[8:3], act[2], act[1], act[0],
                     exp[21], exp[20], exp[19:15], exp[14:9], exp[8:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input logic run, input logic req, input logic [4:0] lh,
                        input logic [5:0] lm, input logic [5:0] ls);
        run_en = run; load_req = req; load_hour = lh; load_min = lm; load_sec = ls;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Free-running count from reset: tick every fourth edge.
        for (int r = 0; r < 3; r++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        for (int r = 0; r < 3; r++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
        // Load 23:59:58 and roll over midnight.
        add(1, 1, 23, 59, 58, 1, 0, 23, 59, 58, 0, 0);
        for (int r = 0; r < 3; r++) add(1, 0, 0, 0, 0, 0, 0, 23, 59, 58, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 23, 59, 59, 1, 0);
        for (int r = 0; r < 3; r++) add(1, 0, 0, 0, 0, 0, 0, 23, 59, 59, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Out-of-range loads with time frozen.
        add(0, 1, 24, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 12, 60, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 12, 0, 60, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Second prescaler count, freeze for 7 cycles, then 2 enabled cycles to the tick.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 7; r++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        // Load on the terminal-count edge discards the tick.
        for (int r = 0; r < 3; r++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 1, 10, 20, 30, 1, 0, 10, 20, 30, 0, 0);
        for (int r = 0; r < 3; r++) add(1, 0, 0, 0, 0, 0, 0, 10, 20, 30, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 10, 20, 31, 1, 0);
        // Request held 10 cycles: one ack; re-raise: second ack.
        add(0, 1, 1, 2, 3, 1, 0, 1, 2, 3, 0, 0);
        for (int r = 0; r < 9; r++) add(0, 1, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0);
        add(0, 1, 4, 5, 6, 1, 0, 4, 5, 6, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 4, 5, 6, 0, 0);

        #1 reset_n = 1'b0;
        #2 check("reset_state", '0);
        reset_n = 1'b1;

        foreach (tv[i]) begin
            step(tv[i].run, tv[i].req, tv[i].lh, tv[i].lm, tv[i].ls);
            check($sformatf("vector_%0d", i), tv[i].exp);
        end

        // Reset in mid-handshake: a still-high request after release is a new one.
        step(1, 1, 7, 8, 9);
        check("hs_first_ack", mk_exp(1, 0, 7, 8, 9, 0, 0, 1));
        step(1, 1, 7, 8, 9);
        check("hs_held_no_ack", mk_exp(0, 0, 7, 8, 9, 0, 0, 1));
        #2 reset_n = 1'b0;
        #1 check("async_reset_hs", '0);
        reset_n = 1'b1;
        step(1, 1, 7, 8, 9);
        check("hs_reack_after_reset", mk_exp(1, 0, 7, 8, 9, 0, 0, 1));
        for (int r = 1; r <= 4; r++) begin
            step(1, 0, 0, 0, 0);
            check($sformatf("after_reload_edge_%0d", r),
                  mk_exp(0, 0, 7, 8, (r == 4) ? 6'd10 : 6'd9, r == 4, 0, 1));
        end

        // Reset in mid-second: the partial second is discarded.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("pre_reset_partial", mk_exp(0, 0, 7, 8, 10, 0, 0, 1));
        #3 reset_n = 1'b0;
        #1 check("async_reset_mid_sec", '0);
        reset_n = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            step(1, 0, 0, 0, 0);
            check($sformatf("post_reset_edge_%0d", r),
                  mk_exp(0, 0, 0, 0, (r == 4) ? 6'd1 : 6'd0, r == 4, 0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
